// File: rtl/execute_alu_cc.sv
// Execute stage of a Y86-64 style pipeline: ALU, condition-code register,
// branch/cmov condition evaluation and the E->M pipeline register.
module execute_alu_cc #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] aluA_i,
    input  logic [DATA_WIDTH-1:0] aluB_i,
    input  logic [3:0]            fun_i,
    input  logic [3:0]            E_icode_i,
    input  logic [3:0]            E_ifun_i,
    input  logic [DATA_WIDTH-1:0] E_valA_i,
    input  logic [3:0]            E_dstE_i,
    input  logic [3:0]            E_dstM_i,
    input  logic                  set_cc_i,
    input  logic                  cc_inhibit_i,
    input  logic                  M_stall_i,
    input  logic                  M_bubble_i,
    output logic [DATA_WIDTH-1:0] e_valE_o,
    output logic                  e_cnd_o,
    output logic [3:0]            e_dstE_o,
    output logic [2:0]            cc_o,
    output logic [3:0]            M_icode_o,
    output logic [3:0]            M_ifun_o,
    output logic                  M_cnd_o,
    output logic [DATA_WIDTH-1:0] M_valE_o,
    output logic [DATA_WIDTH-1:0] M_valA_o,
    output logic [3:0]            M_dstE_o,
    output logic [3:0]            M_dstM_o
);

    localparam logic [3:0] IcNop  = 4'h1;
    localparam logic [3:0] IcCxx  = 4'h2;
    localparam logic [3:0] IcJxx  = 4'h7;
    localparam logic [3:0] FnAdd  = 4'h0;
    localparam logic [3:0] FnSub  = 4'h1;
    localparam logic [3:0] FnAnd  = 4'h2;
    localparam logic [3:0] FnXor  = 4'h3;
    localparam logic [3:0] RNone  = 4'hF;
    localparam logic [2:0] CcReset = 3'b100;

    typedef struct packed {
        logic [3:0]            icode;
        logic [3:0]            ifun;
        logic                  cnd;
        logic [DATA_WIDTH-1:0] valE;
        logic [DATA_WIDTH-1:0] valA;
        logic [3:0]            dstE;
        logic [3:0]            dstM;
    } m_reg_t;

    localparam m_reg_t MBubble = '{
        icode: IcNop, ifun: 4'h0, cnd: 1'b0, valE: '0, valA: '0, dstE: RNone, dstM: RNone
    };

    logic [DATA_WIDTH-1:0] result;
    logic                  zf, sf, of;
    logic [2:0]            cc_d, cc_q;
    m_reg_t                m_d, m_q;
    logic                  cc_zf, cc_sf, cc_of;
    logic                  cond;

    // ALU and the flags it would produce this cycle
    always_comb begin
        result = '0;
        of     = 1'b0;
        unique case (fun_i)
            FnAdd: begin
                result = aluA_i + aluB_i;
                of = (aluA_i[DATA_WIDTH-1] == aluB_i[DATA_WIDTH-1]) &&
                     (result[DATA_WIDTH-1] != aluA_i[DATA_WIDTH-1]);
            end
            FnSub: begin
                result = aluA_i - aluB_i;
                of = (aluA_i[DATA_WIDTH-1] != aluB_i[DATA_WIDTH-1]) &&
                     (result[DATA_WIDTH-1] != aluA_i[DATA_WIDTH-1]);
            end
            FnAnd:   result = aluA_i & aluB_i;
            FnXor:   result = aluA_i ^ aluB_i;
            default: result = '0;
        endcase
        zf = (result == '0);
        sf = result[DATA_WIDTH-1];
    end

    // Condition is evaluated against the registered CC only, so a same-cycle
    // update never leaks into this cycle's branch/cmov decision.
    assign {cc_zf, cc_sf, cc_of} = cc_q;

    always_comb begin
        cond = 1'b0;
        unique case (E_ifun_i)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (cc_sf ^ cc_of) | cc_zf;
            4'h2:    cond = cc_sf ^ cc_of;
            4'h3:    cond = cc_zf;
            4'h4:    cond = ~cc_zf;
            4'h5:    cond = ~(cc_sf ^ cc_of);
            4'h6:    cond = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: cond = 1'b0;
        endcase
    end

    assign e_valE_o = result;
    assign e_cnd_o  = ((E_icode_i == IcCxx) || (E_icode_i == IcJxx)) ? cond : 1'b0;
    assign e_dstE_o = ((E_icode_i == IcCxx) && !e_cnd_o) ? RNone : E_dstE_i;

    always_comb begin
        cc_d = cc_q;
        if (rst_i) begin
            cc_d = CcReset;
        end else if (set_cc_i && !cc_inhibit_i) begin
            cc_d = {zf, sf, of};
        end
    end

    always_comb begin
        m_d = m_q;
        if (rst_i) begin
            m_d = MBubble;
        end else if (M_stall_i) begin
            m_d = m_q;
        end else if (M_bubble_i) begin
            m_d = MBubble;
        end else begin
            m_d = '{
                icode: E_icode_i, ifun: E_ifun_i, cnd: e_cnd_o, valE: result,
                valA: E_valA_i, dstE: e_dstE_o, dstM: E_dstM_i
            };
        end
    end

    always_ff @(posedge clk_i) begin
        cc_q <= cc_d;
        m_q  <= m_d;
    end

    assign cc_o      = cc_q;
    assign M_icode_o = m_q.icode;
    assign M_ifun_o  = m_q.ifun;
    assign M_cnd_o   = m_q.cnd;
    assign M_valE_o  = m_q.valE;
    assign M_valA_o  = m_q.valA;
    assign M_dstE_o  = m_q.dstE;
    assign M_dstM_o  = m_q.dstM;

endmodule
